micro_tlb: RTL and testbench
============================

Name: micro_tlb

Overview:
- Parametrised, fully-associative micro-TLB placed in front of the shared joint TLB.
- One instance per fetch or data path serves lookups in the same cycle on a hit.
- On a miss it stalls the requester, fetches both halves of the even/odd page pair from the joint TLB through a request/response handshake, and refills one slot.
- Supports single-cycle flush, issued on any TLBWI/TLBWR or on an EntryHi ASID change.

Parameters:
- ENTRIES, 4, number of micro-TLB slots (≥2, power of two).
- VPN2_W, 19, VPN2 width.
- ASID_W, 8, ASID width.
- PFN_W, 20, PFN width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- lk_valid  in  1  lookup request this cycle.
- lk_vpn2  in  VPN2_W  lookup VPN2.
- lk_odd_page  in  1  VA bit 12; selects the odd half of the pair.
- lk_asid  in  ASID_W  current ASID.
- lk_hit  out  1  valid slot matched (combinational).
- lk_pfn  out  PFN_W  PFN of the selected half.
- lk_c  out  3  cache attribute of the selected half.
- lk_d  out  1  dirty bit of the selected half.
- lk_v  out  1  valid bit of the selected half.
- lk_stall  out  1  requester must hold lk_* stable.
- lk_refill_miss  out  1  one-cycle pulse: joint TLB has no matching entry.
- flush  in  1  invalidate all slots.
- mt_req  out  1  one-cycle request pulse to the joint TLB.
- mt_vpn2  out  VPN2_W  request VPN2, registered.
- mt_asid  out  ASID_W  request ASID, registered.
- mt_resp_valid  in  1  response strobe, ≥1 cycle after mt_req.
- mt_found  in  1  joint TLB hit.
- mt_g  in  1  global bit.
- mt_pfn0, mt_pfn1  in  PFN_W  PFNs of the even/odd halves.
- mt_c0, mt_c1  in  3  cache attributes of the even/odd halves.
- mt_d0, mt_d1, mt_v0, mt_v1  in  1  dirty and valid bits of the even/odd halves.

Behaviour:

Reset and clocking
- Reset is synchronous and active-high; single clock domain.
- On reset: all slot valid flags are 0, state is IDLE, victim pointer is 0, mt_req is 0, lk_refill_miss is 0, and mt_vpn2/mt_asid are 0.

Slot contents and matching
- Each slot holds: valid flag, vpn2, asid, g, and pfn/c/d/v for both halves.
- A slot matches when its valid flag is 1, vpn2 == lk_vpn2, and (asid == lk_asid or g).
- lk_hit = lk_valid and any match. At most one slot can match; refill occurs only on a miss.
- lk_pfn/c/d/v come from the matching slot's half selected by lk_odd_page. They are 0 when lk_hit = 0.
- lk_v = 0 still counts as a hit; the invalid-page exception is raised downstream, not here.

Stall
- lk_stall = lk_valid and (not lk_hit or state != IDLE).

State machine (IDLE, WAIT, DROP)
- IDLE:
  - On lk_valid, no hit, and no flush: pulse mt_req for 1 cycle, latch lk_vpn2/lk_asid into mt_vpn2/mt_asid, then go to WAIT.
  - Miss with flush in the same cycle: no request is issued; the lookup is retried next cycle.
- WAIT, on mt_resp_valid:
  - If flush is asserted in the same cycle: discard the response and go to IDLE.
  - Else if mt_found: write the slot at the victim choice with valid=1, vpn2/asid from the latched values, and g/halves from mt_*. Go to IDLE. The hit is visible the following cycle.
  - Else (not found): pulse lk_refill_miss for 1 cycle, write nothing, and go to IDLE.
- WAIT, on flush without mt_resp_valid: go to DROP.
- DROP: on mt_resp_valid, discard the response, do not pulse lk_refill_miss, and go to IDLE.

Victim selection
- The victim is the lowest-index invalid slot if one exists.
- Otherwise it is the round-robin pointer, which then increments modulo ENTRIES, wrapping ENTRIES-1 → 0.
- The pointer advances only on a refill into a full array.

Flush
- flush clears every slot's valid flag at the clock edge, in any state.
- The victim pointer is not reset by flush.
- A flush in the same cycle as a refill write wins: the slot ends up invalid.

Protocol rules
- The requester holds lk_* constant while lk_stall = 1.
- The joint TLB accepts a new mt_req only after its previous response has been returned.
- Only one request is ever outstanding.

Test Plan:
- Hit after refill: after reset, lookup vpn2=0x00123, asid=5, odd=1 → mt_req pulses with mt_vpn2=0x00123. Respond 2 cycles later with found=1, pfn1=0xABCDE, v1=1, d1=0, c1=3 → next cycle lk_hit=1, lk_pfn=0xABCDE, lk_c=3, lk_stall=0.
- ASID and global: slot written with asid=5, g=0. Lookup asid=6 misses and issues mt_req. Refill with g=1 → subsequent lookups with asid=6 and asid=9 both hit.
- Refill miss: respond with mt_found=0 → lk_refill_miss is high exactly 1 cycle, state returns to IDLE, and no slot becomes valid.
- Replacement: fill 4 distinct VPNs (slots 0-3), then miss on a 5th → slot 0 is replaced. A 6th miss replaces slot 1. Flush, then a miss → lowest invalid slot 0 is used.
- Flush races:
  - Flush in the same cycle as mt_resp_valid(found=1) → no slot valid, no lk_refill_miss.
  - Flush while WAITing, then response with found=0 → DROP discards it and no lk_refill_miss pulses.
- Reset mid-operation: assert rst while in WAIT → next cycle all outputs are at reset values and a later stray mt_resp_valid is ignored; a following lookup re-issues mt_req.

Source files
------------

// File: rtl/micro_tlb_if.sv
`default_nettype none
// ============================================================================
//  Module      : micro_tlb_if
//  Description : Lookup, flush and joint-TLB refill signals of the micro-TLB.
//  Revision    : 1.0 - initial release
// ============================================================================
interface micro_tlb_if #(
    parameter int VPN2_W = 19,
    parameter int ASID_W = 8,
    parameter int PFN_W  = 20
);
    // Requester side
    logic              lk_valid;
    logic [VPN2_W-1:0] lk_vpn2;
    logic              lk_odd_page;
    logic [ASID_W-1:0] lk_asid;
    logic              lk_hit;
    logic [PFN_W-1:0]  lk_pfn;
    logic [2:0]        lk_c;
    logic              lk_d;
    logic              lk_v;
    logic              lk_stall;
    logic              lk_refill_miss;
    logic              flush;

    // Joint-TLB side
    logic              mt_req;
    logic [VPN2_W-1:0] mt_vpn2;
    logic [ASID_W-1:0] mt_asid;
    logic              mt_resp_valid;
    logic              mt_found;
    logic              mt_g;
    logic [PFN_W-1:0]  mt_pfn0;
    logic [PFN_W-1:0]  mt_pfn1;
    logic [2:0]        mt_c0;
    logic [2:0]        mt_c1;
    logic              mt_d0;
    logic              mt_d1;
    logic              mt_v0;
    logic              mt_v1;

    modport slave (
        input  lk_valid, lk_vpn2, lk_odd_page, lk_asid, flush,
        input  mt_resp_valid, mt_found, mt_g, mt_pfn0, mt_pfn1,
        input  mt_c0, mt_c1, mt_d0, mt_d1, mt_v0, mt_v1,
        output lk_hit, lk_pfn, lk_c, lk_d, lk_v, lk_stall, lk_refill_miss,
        output mt_req, mt_vpn2, mt_asid
    );

    modport master (
        output lk_valid, lk_vpn2, lk_odd_page, lk_asid, flush,
        output mt_resp_valid, mt_found, mt_g, mt_pfn0, mt_pfn1,
        output mt_c0, mt_c1, mt_d0, mt_d1, mt_v0, mt_v1,
        input  lk_hit, lk_pfn, lk_c, lk_d, lk_v, lk_stall, lk_refill_miss,
        input  mt_req, mt_vpn2, mt_asid
    );
endinterface
`default_nettype wire

// File: rtl/micro_tlb.sv
`default_nettype none
// ============================================================================
//  Module      : micro_tlb
//  Description : Fully-associative micro-TLB; same-cycle hits, refill of an
//                even/odd page pair from the joint TLB on a miss.
//  Revision    : 1.0 - initial release
// ============================================================================
module micro_tlb #(
    parameter int ENTRIES = 4,
    parameter int VPN2_W  = 19,
    parameter int ASID_W  = 8,
    parameter int PFN_W   = 20
) (
    input wire logic   clk,
    input wire logic   rst,
    micro_tlb_if.slave bus
);
    localparam int IDX_W = $clog2(ENTRIES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [VPN2_W-1:0]  vpn2_q [ENTRIES];
    logic [ASID_W-1:0]  asid_q [ENTRIES];
    logic [PFN_W-1:0]   pfn0_q [ENTRIES];
    logic [PFN_W-1:0]   pfn1_q [ENTRIES];
    logic [2:0]         c0_q   [ENTRIES];
    logic [2:0]         c1_q   [ENTRIES];
    logic [ENTRIES-1:0] g_q, d0_q, d1_q, v0_q, v1_q;

    logic [IDX_W-1:0]   rr_q, rr_d;
    logic               mt_req_q, mt_req_d;
    logic               miss_q, miss_d;
    logic [VPN2_W-1:0]  mt_vpn2_q, mt_vpn2_d;
    logic [ASID_W-1:0]  mt_asid_q, mt_asid_d;

    logic [ENTRIES-1:0] w_match;
    logic               w_hit;
    logic [PFN_W-1:0]   w_sel_pfn;
    logic [2:0]         w_sel_c;
    logic               w_sel_d;
    logic               w_sel_v;
    logic               w_free_found;
    logic [IDX_W-1:0]   w_free_idx;
    logic [IDX_W-1:0]   w_victim;
    logic               w_wr_en;

    for (genvar i = 0; i < ENTRIES; i++) begin : g_match
        assign w_match[i] = valid_q[i] && (vpn2_q[i] == bus.lk_vpn2) &&
                            ((asid_q[i] == bus.lk_asid) || g_q[i]);
    end

    assign w_hit = bus.lk_valid && (|w_match);

    // At most one slot matches, so the last matching slot is the only one.
    always_comb begin
        w_sel_pfn = '0;
        w_sel_c   = '0;
        w_sel_d   = 1'b0;
        w_sel_v   = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (w_match[i]) begin
                w_sel_pfn = bus.lk_odd_page ? pfn1_q[i] : pfn0_q[i];
                w_sel_c   = bus.lk_odd_page ? c1_q[i]   : c0_q[i];
                w_sel_d   = bus.lk_odd_page ? d1_q[i]   : d0_q[i];
                w_sel_v   = bus.lk_odd_page ? v1_q[i]   : v0_q[i];
            end
        end
    end

    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = IDX_W'(i);
            end
        end
    end

    assign w_victim = w_free_found ? w_free_idx : rr_q;

    always_comb begin
        state_d   = state_q;
        mt_req_d  = 1'b0;
        miss_d    = 1'b0;
        mt_vpn2_d = mt_vpn2_q;
        mt_asid_d = mt_asid_q;
        w_wr_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.lk_valid && !w_hit && !bus.flush) begin
                    mt_req_d  = 1'b1;
                    mt_vpn2_d = bus.lk_vpn2;
                    mt_asid_d = bus.lk_asid;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.mt_resp_valid) begin
                    state_d = S_IDLE;
                    if (!bus.flush) begin
                        if (bus.mt_found) w_wr_en = 1'b1;
                        else              miss_d  = 1'b1;
                    end
                end else if (bus.flush) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (bus.mt_resp_valid) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Flush overrides a same-cycle refill; the round-robin pointer survives it.
    always_comb begin
        valid_d = valid_q;
        rr_d    = rr_q;
        if (w_wr_en) begin
            valid_d[w_victim] = 1'b1;
            if (!w_free_found) rr_d = rr_q + 1'b1;
        end
        if (bus.flush) valid_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            valid_q   <= '0;
            rr_q      <= '0;
            mt_req_q  <= 1'b0;
            miss_q    <= 1'b0;
            mt_vpn2_q <= '0;
            mt_asid_q <= '0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            rr_q      <= rr_d;
            mt_req_q  <= mt_req_d;
            miss_q    <= miss_d;
            mt_vpn2_q <= mt_vpn2_d;
            mt_asid_q <= mt_asid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            vpn2_q[w_victim] <= mt_vpn2_q;
            asid_q[w_victim] <= mt_asid_q;
            g_q[w_victim]    <= bus.mt_g;
            pfn0_q[w_victim] <= bus.mt_pfn0;
            pfn1_q[w_victim] <= bus.mt_pfn1;
            c0_q[w_victim]   <= bus.mt_c0;
            c1_q[w_victim]   <= bus.mt_c1;
            d0_q[w_victim]   <= bus.mt_d0;
            d1_q[w_victim]   <= bus.mt_d1;
            v0_q[w_victim]   <= bus.mt_v0;
            v1_q[w_victim]   <= bus.mt_v1;
        end
    end

    assign bus.lk_hit         = w_hit;
    assign bus.lk_pfn         = w_hit ? w_sel_pfn : '0;
    assign bus.lk_c           = w_hit ? w_sel_c   : '0;
    assign bus.lk_d           = w_hit && w_sel_d;
    assign bus.lk_v           = w_hit && w_sel_v;
    assign bus.lk_stall       = bus.lk_valid && (!w_hit || (state_q != S_IDLE));
    assign bus.lk_refill_miss = miss_q;
    assign bus.mt_req         = mt_req_q;
    assign bus.mt_vpn2        = mt_vpn2_q;
    assign bus.mt_asid        = mt_asid_q;

endmodule
`default_nettype wire

// File: tb/tb_micro_tlb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_micro_tlb
//  Description : Directed scoreboard bench for micro_tlb.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_micro_tlb;
    localparam int ENTRIES = 4;
    localparam int VPN2_W  = 19;
    localparam int ASID_W  = 8;
    localparam int PFN_W   = 20;

    typedef struct packed {
        logic [PFN_W-1:0] pfn;
        logic [2:0]       c;
        logic             d;
        logic             v;
    } lk_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    micro_tlb_if #(.VPN2_W(VPN2_W), .ASID_W(ASID_W), .PFN_W(PFN_W)) bus ();

    micro_tlb #(
        .ENTRIES(ENTRIES), .VPN2_W(VPN2_W), .ASID_W(ASID_W), .PFN_W(PFN_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [VPN2_W+ASID_W-1:0] exp_req_q [$];
    lk_exp_t                  exp_lk_q  [$];
    int                       exp_miss = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares every DUT event against the scoreboard queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mt_req) begin
                check("mt_req_expected", 64'(exp_req_q.size() != 0), 64'd1);
                if (exp_req_q.size() != 0) begin
                    logic [VPN2_W+ASID_W-1:0] e;
                    e = exp_req_q.pop_front();
                    check("mt_req_vpn2_asid", 64'({bus.mt_vpn2, bus.mt_asid}), 64'(e));
                end
            end
            if (bus.lk_valid && bus.lk_hit) begin
                check("lk_hit_expected", 64'(exp_lk_q.size() != 0), 64'd1);
                if (exp_lk_q.size() != 0) begin
                    lk_exp_t e;
                    e = exp_lk_q.pop_front();
                    check("lk_pfn", 64'(bus.lk_pfn), 64'(e.pfn));
                    check("lk_c", 64'(bus.lk_c), 64'(e.c));
                    check("lk_d", 64'(bus.lk_d), 64'(e.d));
                    check("lk_v", 64'(bus.lk_v), 64'(e.v));
                    check("lk_stall_on_hit", 64'(bus.lk_stall), 64'd0);
                end
            end
            if (bus.lk_refill_miss) begin
                check("refill_miss_expected", 64'(exp_miss > 0), 64'd1);
                if (exp_miss > 0) exp_miss--;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_lk(input logic [VPN2_W-1:0] vpn, input logic [ASID_W-1:0] asid,
                            input logic odd);
        bus.lk_valid    = 1'b1;
        bus.lk_vpn2     = vpn;
        bus.lk_asid     = asid;
        bus.lk_odd_page = odd;
    endtask

    task automatic exp_hit(input logic [PFN_W-1:0] pfn, input logic [2:0] c,
                           input logic d, input logic v);
        lk_exp_t e;
        e.pfn = pfn; e.c = c; e.d = d; e.v = v;
        exp_lk_q.push_back(e);
    endtask

    task automatic drive_resp(input logic found, input logic g,
                              input logic [PFN_W-1:0] p0, input logic [PFN_W-1:0] p1,
                              input logic [2:0] c0, input logic [2:0] c1,
                              input logic [1:0] dv0, input logic [1:0] dv1);
        bus.mt_resp_valid = 1'b1;
        bus.mt_found = found; bus.mt_g = g;
        bus.mt_pfn0 = p0; bus.mt_pfn1 = p1;
        bus.mt_c0 = c0; bus.mt_c1 = c1;
        {bus.mt_d0, bus.mt_v0} = dv0;
        {bus.mt_d1, bus.mt_v1} = dv1;
    endtask

    task automatic hit(input logic [VPN2_W-1:0] vpn, input logic [ASID_W-1:0] asid,
                       input logic odd, input logic [PFN_W-1:0] pfn, input logic [2:0] c,
                       input logic d, input logic v);
        exp_hit(pfn, c, d, v);
        start_lk(vpn, asid, odd);
        step(1);
        bus.lk_valid = 1'b0;
    endtask

    // Miss, request, response two cycles after mt_req, hit visible next cycle.
    task automatic miss_refill(input logic [VPN2_W-1:0] vpn, input logic [ASID_W-1:0] asid,
                               input logic odd, input logic g,
                               input logic [PFN_W-1:0] p0, input logic [PFN_W-1:0] p1,
                               input logic [2:0] c0, input logic [2:0] c1,
                               input logic [1:0] dv0, input logic [1:0] dv1);
        exp_req_q.push_back({vpn, asid});
        if (odd) exp_hit(p1, c1, dv1[1], dv1[0]);
        else     exp_hit(p0, c0, dv0[1], dv0[0]);
        start_lk(vpn, asid, odd);
        step(2);
        drive_resp(1'b1, g, p0, p1, c0, c1, dv0, dv1);
        step(1);
        bus.mt_resp_valid = 1'b0;
        step(1);
        bus.lk_valid = 1'b0;
    endtask

    task automatic miss_not_found(input logic [VPN2_W-1:0] vpn, input logic [ASID_W-1:0] asid);
        exp_req_q.push_back({vpn, asid});
        exp_miss++;
        start_lk(vpn, asid, 1'b0);
        step(2);
        drive_resp(1'b0, 1'b0, '0, '0, '0, '0, '0, '0);
        step(1);
        bus.mt_resp_valid = 1'b0;
        bus.lk_valid      = 1'b0;
        step(2);
    endtask

    task automatic fill(input logic [VPN2_W-1:0] vpn, input logic [PFN_W-1:0] base);
        miss_refill(vpn, 8'd5, 1'b0, 1'b0, base, base | 20'd1, 3'd0, 3'd1, 2'b11, 2'b11);
    endtask

    initial begin
        bus.lk_valid = 1'b0; bus.lk_vpn2 = '0; bus.lk_odd_page = 1'b0; bus.lk_asid = '0;
        bus.flush = 1'b0;
        bus.mt_resp_valid = 1'b0; bus.mt_found = 1'b0; bus.mt_g = 1'b0;
        bus.mt_pfn0 = '0; bus.mt_pfn1 = '0; bus.mt_c0 = '0; bus.mt_c1 = '0;
        bus.mt_d0 = 1'b0; bus.mt_d1 = 1'b0; bus.mt_v0 = 1'b0; bus.mt_v1 = 1'b0;

        step(3);
        check("rst_mt_req", 64'(bus.mt_req), 64'd0);
        check("rst_refill_miss", 64'(bus.lk_refill_miss), 64'd0);
        check("rst_mt_vpn2", 64'(bus.mt_vpn2), 64'd0);
        check("rst_mt_asid", 64'(bus.mt_asid), 64'd0);
        check("rst_lk_hit", 64'(bus.lk_hit), 64'd0);
        check("rst_lk_stall", 64'(bus.lk_stall), 64'd0);
        rst = 1'b0;
        step(1);

        // Hit after refill, both halves
        miss_refill(19'h00123, 8'd5, 1'b1, 1'b0, 20'h11111, 20'hABCDE, 3'd2, 3'd3, 2'b11, 2'b01);
        hit(19'h00123, 8'd5, 1'b0, 20'h11111, 3'd2, 1'b1, 1'b1);

        // ASID mismatch misses; global refill hits any ASID (v=0 still hits)
        miss_refill(19'h00123, 8'd6, 1'b0, 1'b1, 20'h22220, 20'h22221, 3'd0, 3'd1, 2'b00, 2'b10);
        hit(19'h00123, 8'd6, 1'b1, 20'h22221, 3'd1, 1'b1, 1'b0);
        hit(19'h00123, 8'd9, 1'b0, 20'h22220, 3'd0, 1'b0, 1'b0);

        // Refill miss leaves the slot invalid, so the next lookup requests again
        miss_not_found(19'h00200, 8'd5);
        miss_refill(19'h00200, 8'd5, 1'b0, 1'b0, 20'h33330, 20'h33331, 3'd4, 3'd5, 2'b11, 2'b11);
        miss_refill(19'h00300, 8'd5, 1'b1, 1'b0, 20'h44440, 20'h44441, 3'd6, 3'd7, 2'b01, 2'b10);

        // Full array: round-robin evicts slot 0 then slot 1
        miss_refill(19'h00400, 8'd5, 1'b0, 1'b0, 20'h55550, 20'h55551, 3'd1, 3'd2, 2'b11, 2'b11);
        hit(19'h00123, 8'd9, 1'b1, 20'h22221, 3'd1, 1'b1, 1'b0);
        hit(19'h00200, 8'd5, 1'b1, 20'h33331, 3'd5, 1'b1, 1'b1);
        hit(19'h00300, 8'd5, 1'b0, 20'h44440, 3'd6, 1'b0, 1'b1);
        miss_refill(19'h00500, 8'd5, 1'b1, 1'b0, 20'h66660, 20'h66661, 3'd3, 3'd4, 2'b10, 2'b01);
        hit(19'h00400, 8'd5, 1'b1, 20'h55551, 3'd2, 1'b1, 1'b1);
        hit(19'h00200, 8'd5, 1'b0, 20'h33330, 3'd4, 1'b1, 1'b1);
        hit(19'h00300, 8'd5, 1'b1, 20'h44441, 3'd7, 1'b1, 1'b0);
        miss_not_found(19'h00123, 8'd9);

        // Flush: refill restarts at slot 0, pointer (now 2) is preserved
        bus.flush = 1'b1;
        step(1);
        bus.flush = 1'b0;
        miss_not_found(19'h00400, 8'd5);
        fill(19'h00600, 20'h70000);
        fill(19'h00700, 20'h71000);
        fill(19'h00800, 20'h72000);
        fill(19'h00900, 20'h73000);
        fill(19'h00A00, 20'h74000);
        hit(19'h00600, 8'd5, 1'b1, 20'h70001, 3'd1, 1'b1, 1'b1);
        hit(19'h00700, 8'd5, 1'b1, 20'h71001, 3'd1, 1'b1, 1'b1);
        hit(19'h00900, 8'd5, 1'b1, 20'h73001, 3'd1, 1'b1, 1'b1);
        hit(19'h00A00, 8'd5, 1'b1, 20'h74001, 3'd1, 1'b1, 1'b1);
        miss_not_found(19'h00800, 8'd5);

        // Flush racing a found response: nothing written, no miss pulse
        exp_req_q.push_back({19'h00B00, 8'd5});
        start_lk(19'h00B00, 8'd5, 1'b0);
        step(2);
        drive_resp(1'b1, 1'b0, 20'h7B000, 20'h7B001, 3'd0, 3'd1, 2'b11, 2'b11);
        bus.flush = 1'b1;
        step(1);
        bus.mt_resp_valid = 1'b0;
        bus.flush         = 1'b0;
        bus.lk_valid      = 1'b0;
        step(2);
        miss_not_found(19'h00B00, 8'd5);

        // Miss with flush in IDLE: request deferred by one cycle
        exp_req_q.push_back({19'h00C00, 8'd5});
        exp_hit(20'h7C000, 3'd0, 1'b1, 1'b1);
        start_lk(19'h00C00, 8'd5, 1'b0);
        bus.flush = 1'b1;
        step(1);
        bus.flush = 1'b0;
        check("no_req_with_flush", 64'(bus.mt_req), 64'd0);
        step(2);
        drive_resp(1'b1, 1'b0, 20'h7C000, 20'h7C001, 3'd0, 3'd1, 2'b11, 2'b11);
        step(1);
        bus.mt_resp_valid = 1'b0;
        step(1);
        bus.lk_valid = 1'b0;

        // Flush while waiting: response dropped silently, lookup re-requests
        exp_req_q.push_back({19'h00D00, 8'd5});
        exp_req_q.push_back({19'h00D00, 8'd5});
        exp_hit(20'h7D001, 3'd1, 1'b1, 1'b1);
        start_lk(19'h00D00, 8'd5, 1'b1);
        step(1);
        bus.flush = 1'b1;
        step(1);
        bus.flush = 1'b0;
        drive_resp(1'b0, 1'b0, '0, '0, '0, '0, '0, '0);
        step(1);
        bus.mt_resp_valid = 1'b0;
        step(2);
        drive_resp(1'b1, 1'b0, 20'h7D000, 20'h7D001, 3'd0, 3'd1, 2'b11, 2'b11);
        step(1);
        bus.mt_resp_valid = 1'b0;
        step(1);
        bus.lk_valid = 1'b0;

        // Reset while waiting; stray response ignored; slots cleared
        exp_req_q.push_back({19'h00E00, 8'd5});
        start_lk(19'h00E00, 8'd5, 1'b0);
        step(2);
        rst          = 1'b1;
        bus.lk_valid = 1'b0;
        step(1);
        check("midrst_mt_req", 64'(bus.mt_req), 64'd0);
        check("midrst_mt_vpn2", 64'(bus.mt_vpn2), 64'd0);
        check("midrst_mt_asid", 64'(bus.mt_asid), 64'd0);
        check("midrst_refill_miss", 64'(bus.lk_refill_miss), 64'd0);
        rst = 1'b0;
        step(1);
        drive_resp(1'b0, 1'b0, '0, '0, '0, '0, '0, '0);
        step(1);
        bus.mt_resp_valid = 1'b0;
        step(2);
        fill(19'h00600, 20'h70000);

        step(3);
        check("req_queue_drained", 64'(exp_req_q.size()), 64'd0);
        check("hit_queue_drained", 64'(exp_lk_q.size()), 64'd0);
        check("miss_pulses_seen", 64'(exp_miss), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
